// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared load/store encodings and access-size decode
package dmem_ctrl_pkg;

    localparam logic [2:0] INST_BYTE        = 3'b000;
    localparam logic [2:0] INST_HALF_WORD   = 3'b001;
    localparam logic [2:0] INST_WORD        = 3'b010;
    localparam logic [2:0] INST_BYTE_U      = 3'b100;
    localparam logic [2:0] INST_HALF_WORD_U = 3'b101;

    localparam int BYTE      = 8;
    localparam int HALF_WORD = 16;
    localparam int ROM       = 32;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_NONE
    } acc_size_e;

    // Stores have no unsigned variants, so funct3[2] makes a store invalid.
    function automatic acc_size_e decode_size(input logic [2:0] f3, input logic is_store);
        acc_size_e sz;
        case (f3)
            INST_BYTE, INST_BYTE_U:           sz = SZ_BYTE;
            INST_HALF_WORD, INST_HALF_WORD_U: sz = SZ_HALF;
            INST_WORD:                        sz = SZ_WORD;
            default:                          sz = SZ_NONE;
        endcase
        if (is_store && f3[2]) sz = SZ_NONE;
        return sz;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - DEPTHx32 synchronous RAM with byte write enables and registered read
module dmem_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [3:0]               we,
    input  logic [31:0]              wdata,
    input  logic                     re,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage data memory responder with wait states and byte lanes
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wmem_en_i,
    input  logic        rmem_en_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] mem_rdata_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        misalign_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e        state, state_nxt;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;
    logic          store_q;
    logic [3:0]    wait_cnt;

    logic          req;
    acc_size_e     size;
    logic [1:0]    a;
    logic          misalign;
    logic          access_ok;
    logic [3:0]    strb;
    logic [31:0]   lane_data;
    logic          access_now;
    logic [3:0]    ram_we;
    logic          ram_re;
    logic [31:0]   ram_rdata;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    // Address bits above the RAM index wrap by design.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, mem_addr_i[31:AW+2]};

    assign req = wmem_en_i | rmem_en_i;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY:    if (wait_cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Store wins when both enables are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            store_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    addr_q   <= mem_addr_i[AW+1:0];
                    wdata_q  <= mem_wdata_i;
                    f3_q     <= funct3_i;
                    store_q  <= wmem_en_i;
                    wait_cnt <= 4'(WAIT_CYCLES);
                end
                BUSY: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        a         = addr_q[1:0];
        size      = decode_size(f3_q, store_q);
        misalign  = ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'd0));
        access_ok = (size != SZ_NONE) && !misalign;
        strb      = 4'b0000;
        lane_data = wdata_q;
        load_data = 32'd0;
        shifted   = ram_rdata >> {a, 3'b000};
        case (size)
            SZ_BYTE: begin
                strb      = 4'b0001 << a;
                lane_data = {4{wdata_q[BYTE-1:0]}};
                load_data = {24'd0, shifted[BYTE-1:0]};
            end
            SZ_HALF: begin
                strb      = 4'b0011 << a;
                lane_data = {2{wdata_q[HALF_WORD-1:0]}};
                load_data = {16'd0, shifted[HALF_WORD-1:0]};
            end
            SZ_WORD: begin
                strb      = 4'b1111;
                load_data = shifted;
            end
            default: ;
        endcase
        access_now = (state == BUSY) && (wait_cnt == 4'd0) && access_ok;
        // A write falling on the reset edge is dropped.
        ram_we     = (access_now && store_q && !rst) ? strb : 4'b0000;
        ram_re     = access_now && !store_q;
    end

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .addr  (addr_q[AW+1:2]),
        .we    (ram_we),
        .wdata (lane_data),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    // Request registers are still held in DONE, so the load qualifiers are valid there.
    always_comb begin
        mem_rdata_o = 32'd0;
        stall_o     = 1'b0;
        ack_o       = 1'b0;
        misalign_o  = 1'b0;
        case (state)
            IDLE: stall_o = req;
            BUSY: stall_o = 1'b1;
            DONE: begin
                ack_o      = 1'b1;
                misalign_o = misalign;
                if (!store_q && access_ok) mem_rdata_o = load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, we0, re0, stall0, ack0, mis0;
    logic [31:0] addr0, wd0, rd0;
    logic [2:0]  f30;
    logic        rst3, we3, re3, stall3, ack3, mis3;
    logic [31:0] addr3, wd3, rd3;
    logic [2:0]  f33;

    dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst0), .wmem_en_i(we0), .rmem_en_i(re0), .mem_addr_i(addr0),
        .mem_wdata_i(wd0), .funct3_i(f30), .mem_rdata_o(rd0), .stall_o(stall0),
        .ack_o(ack0), .misalign_o(mis0)
    );

    dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst3), .wmem_en_i(we3), .rmem_en_i(re3), .mem_addr_i(addr3),
        .mem_wdata_i(wd3), .funct3_i(f33), .mem_rdata_o(rd3), .stall_o(stall3),
        .ack_o(ack3), .misalign_o(mis3)
    );

    typedef struct {
        logic        st;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          ack_cyc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic st, input logic ld, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                input logic [31:0] exp_rdata, input logic exp_mis);
        vec_t v;
        v.st = st; v.ld = ld; v.addr = addr; v.wdata = wdata; v.f3 = f3;
        v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic drive(input bit d3, input logic st, input logic ld, input logic [31:0] a,
                         input logic [31:0] w, input logic [2:0] f);
        if (d3) begin we3 = st; re3 = ld; addr3 = a; wd3 = w; f33 = f; end
        else    begin we0 = st; re0 = ld; addr0 = a; wd0 = w; f30 = f; end
    endtask

    task automatic sample(input bit d3, output logic [31:0] rd, output logic st,
                          output logic ak, output logic ms);
        if (d3) begin rd = rd3; st = stall3; ak = ack3; ms = mis3; end
        else    begin rd = rd0; st = stall0; ak = ack0; ms = mis0; end
    endtask

    task automatic run_access(input bit d3, input string tag, input vec_t v);
        exp_t        e;
        exp_t        got_e;
        logic [31:0] rd;
        logic        st, ak, ms;
        int          nst;
        bit          done;
        e.rdata   = v.exp_rdata;
        e.mis     = v.exp_mis;
        e.ack_cyc = d3 ? 5 : 2;
        sb_q.push_back(e);
        drive(d3, v.st, v.ld, v.addr, v.wdata, v.f3);
        nst  = 0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            sample(d3, rd, st, ak, ms);
            if (ak) begin
                done  = 1;
                got_e = sb_q.pop_front();
                check({tag, " ack_cycle"}, 32'(c), 32'(got_e.ack_cyc));
                check({tag, " stall_cycles"}, 32'(nst), 32'(got_e.ack_cyc));
                check({tag, " rdata"}, rd, got_e.rdata);
                check({tag, " misalign"}, 32'(ms), 32'(got_e.mis));
                check({tag, " stall_in_done"}, 32'(st), 32'd0);
            end else if (st) begin
                nst++;
            end
            @(negedge clk);
        end
        if (!done) begin
            check({tag, " ack_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
        drive(d3, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        #1;
        sample(d3, rd, st, ak, ms);
        check({tag, " ack_one_cycle"}, 32'(ak), 32'd0);
        check({tag, " rdata_idle"}, rd, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic        ack_seen;
        logic [31:0] rd;
        logic        st, ak, ms;

        vecs.push_back(mk(1, 0, 32'h10,  32'hDEADBEEF, INST_WORD,        32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h10,  32'h0,        INST_WORD,        32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 0, 32'h11,  32'h5A,       INST_BYTE,        32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h10,  32'h0,        INST_WORD,        32'hDEAD5AEF, 0));
        vecs.push_back(mk(1, 0, 32'h12,  32'h1234,     INST_HALF_WORD,   32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h10,  32'h0,        INST_WORD,        32'h12345AEF, 0));
        vecs.push_back(mk(0, 1, 32'h13,  32'h0,        INST_BYTE_U,      32'h12,       0));
        vecs.push_back(mk(0, 1, 32'h12,  32'h0,        INST_HALF_WORD,   32'h1234,     0));
        vecs.push_back(mk(0, 1, 32'h11,  32'h0,        INST_BYTE,        32'h5A,       0));
        vecs.push_back(mk(0, 1, 32'h11,  32'h0,        INST_HALF_WORD_U, 32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h100, 32'h11223344, INST_WORD,        32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h102, 32'h0,        INST_WORD,        32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h101, 32'hFFFF,     INST_HALF_WORD,   32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h100, 32'h0,        INST_WORD,        32'h11223344, 0));
        vecs.push_back(mk(0, 1, 32'h102, 32'h0,        INST_HALF_WORD_U, 32'h1122,     0));
        vecs.push_back(mk(0, 1, 32'h10,  32'h0,        3'b110,           32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h10,  32'h0,        3'b011,           32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h10,  32'h0,        3'b100,           32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h10,  32'h0,        INST_WORD,        32'h12345AEF, 0));
        vecs.push_back(mk(1, 1, 32'h40,  32'hA5A5A5A5, INST_WORD,        32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h40,  32'h0,        INST_WORD,        32'hA5A5A5A5, 0));
        vecs.push_back(mk(1, 0, 32'h43,  32'hFFFFFF77, INST_BYTE,        32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h40,  32'h0,        INST_WORD,        32'h77A5A5A5, 0));
        vecs.push_back(mk(0, 1, 32'h42,  32'h0,        INST_BYTE,        32'hA5,       0));

        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;
        #1;
        check("reset rdata w0", rd0, 32'd0);
        check("reset stall w0", 32'(stall0), 32'd0);
        check("reset ack w0", 32'(ack0), 32'd0);
        check("reset misalign w0", 32'(mis0), 32'd0);
        check("reset rdata w3", rd3, 32'd0);
        check("reset stall w3", 32'(stall3), 32'd0);
        check("reset ack w3", 32'(ack3), 32'd0);
        check("reset misalign w3", 32'(mis3), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_access(0, $sformatf("w0 vec%0d", i), vecs[i]);
        end

        run_access(1, "w3 sw",        mk(1, 0, 32'h10, 32'h01020304, INST_WORD, 32'h0, 0));
        run_access(1, "w3 lw b2b",    mk(0, 1, 32'h10, 32'h0, INST_WORD, 32'h01020304, 0));
        run_access(1, "w3 lw misal",  mk(0, 1, 32'h21, 32'h0, INST_WORD, 32'h0, 1));
        run_access(1, "w3 sw old",    mk(1, 0, 32'h20, 32'h0BADBEEF, INST_WORD, 32'h0, 0));

        drive(1, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, INST_WORD);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst mid-op busy stall", 32'(stall3), 32'd1);
        rst3 = 1'b1;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        check("rst mid-op rdata", rd3, 32'd0);
        check("rst mid-op stall", 32'(stall3), 32'd0);
        check("rst mid-op ack", 32'(ack3), 32'd0);
        check("rst mid-op misalign", 32'(mis3), 32'd0);
        ack_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            sample(1, rd, st, ak, ms);
            if (ak || st) ack_seen = 1'b1;
        end
        check("rst mid-op no late activity", 32'(ack_seen), 32'd0);
        run_access(1, "w3 lw after rst", mk(0, 1, 32'h20, 32'h0, INST_WORD, 32'h0BADBEEF, 0));
        run_access(1, "w3 sw alias",     mk(1, 0, 32'h1000_0020, 32'hFEEDC0DE, INST_WORD, 32'h0, 0));
        run_access(1, "w3 lw alias",     mk(0, 1, 32'h20, 32'h0, INST_WORD, 32'hFEEDC0DE, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder at the far end of the core's MEM-stage load/store interface. Accepts one load or store per request, turns funct3 and the low address bits into byte-lane strobes, and commits into or reads from a byte-enabled synchronous RAM after a configurable number of wait states. Holds the pipeline with `stall_o` until the access completes. Load data is returned right-justified so the MEM stage only sign- or zero-extends the low byte or halfword.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `WAIT_CYCLES`, 0: extra busy cycles before the RAM access, 0–15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `wmem_en_i` in 1: store request.
- `rmem_en_i` in 1: load request.
- `mem_addr_i` in 32: byte address.
- `mem_wdata_i` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `funct3_i` in 3: access size and signedness, using the shared INST_BYTE/HALF_WORD/WORD/BYTE_U/HALF_WORD_U encodings.
- `mem_rdata_o` out 32: load data, right-justified, upper bits zero.
- `stall_o` out 1: hold the pipeline.
- `ack_o` out 1: one-cycle completion pulse.
- `misalign_o` out 1: one-cycle pulse with `ack_o` when the access was misaligned.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset value is IDLE.
- **IDLE**
  - On `wmem_en_i|rmem_en_i`: latch address, data, funct3 and direction; load `wait_cnt=WAIT_CYCLES`; go to BUSY.
  - If both enables are high, the store wins and the load is ignored.
- **BUSY**
  - While `wait_cnt!=0`, decrement it.
  - When `wait_cnt==0`, perform the access and go to DONE.
- **DONE**
  - Drive `ack_o=1`; go to IDLE unconditionally.
  - Inputs are ignored, so the still-present request is not re-issued.
- **Strobes** (`a=addr[1:0]`)
  - Byte: `1<<a`.
  - Half: `4'b0011<<a`.
  - Word: `4'b1111`.
  - Store data lanes are replicated: byte on all 4 lanes, half on both halves.
- **Misalignment**
  - Condition: half with `a[0]=1`, or word with `a!=0`.
  - Effect: no RAM write, no RAM read, `mem_rdata_o=0`, `misalign_o=1` in DONE.
- **Load return**
  - The RAM word is shifted right by `8*a`, then masked to the access size.
  - Unsigned and signed variants return the same raw bits; extension is done upstream.
- **Invalid funct3**
  - Store with 011/1xx, or load with 011/11x.
  - Treated as aligned, no access, `mem_rdata_o=0`, `ack_o=1`, `misalign_o=0`.
- **Indexing**
  - Word index is `addr[log2(DEPTH)+1:2]`; higher address bits are ignored, so accesses wrap.
- **Reset**
  - Returns the FSM to IDLE and clears all outputs.
  - A write due on the same edge as `rst` is not committed.
  - RAM contents are not cleared.

## Timing
- Reset values: `mem_rdata_o=0`, `stall_o=0`, `ack_o=0`, `misalign_o=0`.
- `stall_o` is combinational: high in IDLE when a request is present, and throughout BUSY. It is low in DONE.
- The request is presented at cycle 0. BUSY spans cycles 1..`WAIT_CYCLES+1`. DONE, with `ack_o` high, is cycle `WAIT_CYCLES+2`.
- The requester holds its inputs stable until the DONE cycle and may present a new request in the cycle after DONE.
- RAM read is synchronous in the last BUSY cycle; `mem_rdata_o` is registered and valid only in DONE, and returns to 0 in IDLE.
- Back-to-back requests start one cycle after DONE. Throughput is one access per `WAIT_CYCLES+3` cycles.

## Structure
- The funct3 encodings and the BYTE/HALF_WORD/ROM width constants belong in the shared header already used by the core.
- The FSM state encoding is local to this block.
- Sub-module `dmem_ram`: DEPTH×32 synchronous RAM with a 4-bit byte write enable and a registered read port. Its interface is address, we[3:0], wdata, re, rdata.
- The FSM, strobe generation, misalignment check and return shifter live in `dmem_ctrl`.

## Test plan
- **SW/LW, WAIT_CYCLES=0:** SW 0xDEADBEEF to addr 0x10, then LW 0x10. Required: `stall_o` high for 2 cycles then DONE with `ack_o` for each access; the load returns 0xDEADBEEF.
- **Byte/half lanes:** after the word above, SB 0x5A to 0x11, then LW 0x10 → 0xDEAD5AEF. Then SH 0x1234 to 0x12, then LW 0x10 → 0x12345AEF. LBU 0x13 → 0x00000012; LH 0x12 → 0x00001234.
- **Misalignment:** LW 0x102 → `misalign_o=1`, `mem_rdata_o=0`. SH 0x101 of 0xFFFF, then LW 0x100 → prior contents unchanged.
- **Wait states, WAIT_CYCLES=3:** LW → `stall_o` high for exactly 5 cycles, `ack_o` on cycle 5. Back-to-back SW then LW to the same word → the load sees the stored value.
- **Reset mid-op, WAIT_CYCLES=3:** SW 0xCAFEF00D to 0x20 with `rst` pulsed in the second BUSY cycle. Required: FSM to IDLE, all outputs 0, and LW 0x20 returns the old value. Also, with DEPTH=1024, SW 0x1000_0020 aliases to 0x20.
- **Both enables high:** store 0xA5A5A5A5 to 0x40 with `rmem_en_i` also asserted → the write commits and `mem_rdata_o=0` in DONE.
